// File: rtl/uart_pkg.sv
// Types and timing helpers shared by the UART receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int freq_mhz, input int bauds);
    return (freq_mhz * 1_000_000 + bauds / 2) / bauds;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output; head reads 0 when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_COUNT);
  assign do_pop   = pop & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: line synchroniser, bit-timing FSM and receive FIFO with status pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQ_MHZ   = 16,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_error_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = clks_per_bit(FREQ_MHZ, BAUDS);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  logic      rx_meta_reg;
  logic      rx_s_reg;
  rx_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic [7:0] shift_reg, shift_next;
  logic       push_byte;
  logic       frame_err;
  logic       fifo_full;
  logic       fifo_empty;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    push_byte    = 1'b0;
    frame_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // Mid-start-bit recheck rejects short low glitches silently.
        if (cnt_reg == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s_reg, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 1'b1;
          if (bit_idx_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            push_byte  = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BREAK: begin
        if (rx_s_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_i  (reset_i),
    .push     (push_byte),
    .push_data(shift_reg),
    .pop      (ready_i),
    .pop_data (data_o),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign valid_o       = ~fifo_empty;
  assign frame_error_o = frame_err;
  // When full the FIFO is non-empty, so ready_i alone decides whether a slot frees up.
  assign overrun_o     = push_byte & fifo_full & ~ready_i;
  assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames plus hand-written corner sequences, scoreboard on pops.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB      = 139;
  localparam int HALF     = 69;
  localparam int PUSH_LAT = 2 + HALF + 9 * CPB;

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       exp_good;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic       frame_error_o;
  logic       overrun_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vrise  = 0;
  int pops   = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] sb [$];
  vec_t vecs [7];

  uart_rx #(
    .FREQ_MHZ(16),
    .BAUDS(115200),
    .FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_error_o(frame_error_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      wait_clks(CPB);
    end
    rx_i = stop_bit;
    wait_clks(CPB);
    rx_i = 1'b1;
  endtask

  // Monitor: pulse counters and scoreboard comparison on every accepted byte.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (frame_error_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (valid_o && !prev_valid) vrise++;
      if (valid_o && ready_i) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got %02h expected no byte", data_o);
        end else begin
          exp_b = sb.pop_front();
          check("pop_data", {24'h0, data_o}, {24'h0, exp_b});
        end
      end
    end
    prev_valid = valid_o;
  end

  initial begin
    int fe0, ov0, v0, p0;
    vecs[0] = '{8'h00, 1'b1, 1'b1};
    vecs[1] = '{8'hFF, 1'b1, 1'b1};
    vecs[2] = '{8'h80, 1'b1, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b1};
    vecs[4] = '{8'h5A, 1'b0, 1'b0};
    vecs[5] = '{8'hC3, 1'b1, 1'b1};
    vecs[6] = '{8'h7E, 1'b1, 1'b1};

    wait_clks(5);
    reset_i = 1'b0;
    wait_clks(3);
    check("reset_valid", valid_o, 0);
    check("reset_data", data_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_flags", {frame_error_o, overrun_o}, 0);

    // Table of frames with the consumer always ready.
    ready_i = 1'b1;
    foreach (vecs[k]) begin
      fe0 = fe_cnt;
      if (vecs[k].exp_good) sb.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop_bit);
      wait_clks(20);
      check("vec_frame_err", fe_cnt - fe0, vecs[k].exp_good ? 0 : 1);
      check("vec_sb_drained", sb.size(), 0);
      check("vec_valid_idle", valid_o, 0);
    end
    ready_i = 1'b0;

    // Single byte held until accepted.
    v0 = vrise;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_clks(5);
    check("t1_valid", valid_o, 1);
    check("t1_data", data_o, 8'hA5);
    wait_clks(50);
    check("t1_hold_data", data_o, 8'hA5);
    check("t1_one_rise", vrise - v0, 1);
    ready_i = 1'b1;
    wait_clks(1);
    ready_i = 1'b0;
    check("t1_valid_after_pop", valid_o, 0);
    check("t1_data_after_pop", data_o, 0);
    check("t1_sb_empty", sb.size(), 0);

    // Back-to-back frames overflow the FIFO on the fifth byte.
    ov0 = ov_cnt;
    p0 = pops;
    for (int i = 1; i <= 4; i++) sb.push_back(8'(i));
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    wait_clks(5);
    check("t2_overrun_once", ov_cnt - ov0, 1);
    check("t2_head", data_o, 8'h01);
    ready_i = 1'b1;
    wait_clks(8);
    ready_i = 1'b0;
    check("t2_pops", pops - p0, 4);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_valid_end", valid_o, 0);

    // Stop bit low, then a good byte.
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    wait_clks(10);
    check("t3_frame_err", fe_cnt - fe0, 1);
    check("t3_no_valid", valid_o, 0);
    ready_i = 1'b1;
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_clks(10);
    ready_i = 1'b0;
    check("t3_good_after", sb.size(), 0);
    check("t3_frame_err_total", fe_cnt - fe0, 1);

    // Short low glitch on the idle line.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0 = vrise;
    rx_i = 1'b0;
    wait_clks(10);
    check("t4_busy_during", busy_o, 1);
    wait_clks(30);
    rx_i = 1'b1;
    wait_clks(100);
    check("t4_busy_after", busy_o, 0);
    check("t4_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    check("t4_no_push", vrise - v0, 0);

    // Reset mid-frame with bytes buffered.
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    wait_clks(5);
    check("t5_buffered", valid_o, 1);
    rx_i = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_i = i[0];
      wait_clks(CPB);
    end
    rx_i = 1'b0;
    wait_clks(CPB / 2);
    check("t5_busy_in_data", busy_o, 1);
    reset_i = 1'b1;
    rx_i = 1'b1;
    wait_clks(1);
    reset_i = 1'b0;
    check("t5_valid_after_reset", valid_o, 0);
    check("t5_busy_after_reset", busy_o, 0);
    check("t5_data_after_reset", data_o, 0);
    wait_clks(2 * CPB);
    check("t5_no_flags", {frame_error_o, overrun_o, valid_o}, 0);
    ready_i = 1'b1;
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    wait_clks(10);
    ready_i = 1'b0;
    check("t5_rx_after_reset", sb.size(), 0);

    // Full FIFO, pop coinciding with the stop-bit sample.
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(8'h11 * i));
      send_frame(8'(8'h11 * i), 1'b1);
    end
    wait_clks(20);
    check("t6_full_head", data_o, 8'h11);
    ov0 = ov_cnt;
    p0 = pops;
    sb.push_back(8'h66);
    fork
      send_frame(8'h66, 1'b1);
      begin
        wait_clks(PUSH_LAT);
        ready_i = 1'b1;
        wait_clks(1);
        ready_i = 1'b0;
      end
    join
    wait_clks(5);
    check("t6_no_overrun", ov_cnt - ov0, 0);
    check("t6_one_pop", pops - p0, 1);
    check("t6_head_advanced", data_o, 8'h22);
    ready_i = 1'b1;
    wait_clks(8);
    ready_i = 1'b0;
    check("t6_total_pops", pops - p0, 5);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_valid_end", valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
